// File: rtl/des_final_perm_out_pkg.sv
// Shared DES definitions for the final-permutation output stage.
// Provides the block/half types, the initial-permutation table shared with
// the IP stage, and a helper that forms the 64-bit preoutput from the
// round-16 halves.
package des_final_perm_out_pkg;

    typedef logic [63:0] block_t;
    typedef logic [31:0] half_t;

    // Entry i names the 1-based source bit that IP moves into bit i
    // (bit 0 = LSB). FP scatters preoutput bit i back to IP_TABLE[i]-1.
    localparam logic [6:0] IP_TABLE [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    // swap = 1 gives R16||L16, the ordering DES feeds into FP.
    function automatic block_t make_preoutput(input half_t left, input half_t right,
                                              input bit swap);
        return swap ? {right, left} : {left, right};
    endfunction

endpackage

// File: rtl/des_fp_map.sv
// DES final permutation (inverse of IP), purely combinational.
// Ports:
//   pre_block - 64-bit preoutput (bit 0 = LSB)
//   fp_block  - 64-bit final-permuted block
module des_fp_map
    import des_final_perm_out_pkg::*;
(
    input  logic [63:0] pre_block,
    output logic [63:0] fp_block
);

    // Scattering through IP_TABLE inverts IP without a second table.
    always_comb begin
        fp_block = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            fp_block[6'(IP_TABLE[6'(i)] - 7'd1)] = pre_block[6'(i)];
        end
    end

endmodule

// File: rtl/des_final_perm_out.sv
// DES output stage: forms the preoutput from the round-16 halves, applies
// the final permutation, and buffers results in a 2-entry FIFO with a
// valid/ready handshake on both sides plus a delivered-block counter.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   left_in, right_in   - round-16 halves
//   in_valid, in_ready  - upstream handshake (in_ready from registered state)
//   out_text            - final-permuted block at the FIFO head
//   out_valid, out_ready- downstream handshake
//   blk_count           - blocks delivered downstream, wraps at 2^CNT_W
module des_final_perm_out
    import des_final_perm_out_pkg::*;
#(
    parameter bit          SWAP_EN = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      left_in,
    input  logic [31:0]      right_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      out_text,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_count
);

    block_t     pre_block;
    block_t     fp_block;
    block_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    always_comb begin
        pre_block = make_preoutput(left_in, right_in, SWAP_EN);
    end

    des_fp_map u_fp_map (
        .pre_block (pre_block),
        .fp_block  (fp_block)
    );

    // Both flags come from count only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        out_text  = mem[rd_ptr];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            blk_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                blk_count <= blk_count + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a write coinciding with rst is dropped so the
    // entries never change under a discarded push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= fp_block;
        end
    end

endmodule

// File: tb/tb_des_final_perm_out.sv
// Bench for des_final_perm_out: two instances (SWAP_EN=1/CNT_W=16 and
// SWAP_EN=0/CNT_W=4). Drivers push the expected block when they issue a
// transaction; negedge monitors compare every presented output against the
// queue head and track occupancy and delivered count independently.
module tb_des_final_perm_out;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a_left, a_right, b_left, b_right;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] a_out_text, b_out_text;
    logic [15:0] a_blk_count;
    logic [3:0]  b_blk_count;

    des_final_perm_out #(.SWAP_EN(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .left_in(a_left), .right_in(a_right),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_text(a_out_text),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .blk_count(a_blk_count)
    );

    des_final_perm_out #(.SWAP_EN(1'b0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .left_in(b_left), .right_in(b_right),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_text(b_out_text),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .blk_count(b_blk_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;
    logic rr_a = 1'b0;
    logic rr_b = 1'b0;

    logic [63:0] a_q[$];
    logic [63:0] b_q[$];
    int          a_occ = 0;
    int          b_occ = 0;
    logic [15:0] a_cnt = '0;
    logic [3:0]  b_cnt = '0;

    // Standard DES IP table, entry i = 1-based source of output bit i (LSB = bit 0).
    int IPT[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

    function automatic logic [63:0] ip_model(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int i = 0; i < 64; i++) r[i] = x[IPT[i]-1];
        return r;
    endfunction

    // FP as the inverse of IP: output bit j takes the preoutput bit that IP
    // would have filled from source j.
    function automatic logic [63:0] fp_model(input logic [63:0] pre);
        logic [63:0] r = '0;
        for (int j = 0; j < 64; j++)
            for (int i = 0; i < 64; i++)
                if (IPT[i] == j + 1) r[j] = pre[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rr_a) a_out_ready = 1'($urandom_range(0, 1));
        if (rr_b) b_out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_in_ready", 64'(a_in_ready), 64'(a_occ != 2));
            chk("a_out_valid", 64'(a_out_valid), 64'(a_occ != 0));
            chk("a_blk_count", 64'(a_blk_count), 64'(a_cnt));
            if (a_out_valid) begin
                chk("a_output_expected", 64'(a_q.size() != 0), 64'(1));
                if (a_q.size() != 0) chk("a_out_text", a_out_text, a_q[0]);
            end
            if (rst) begin
                a_occ = 0;
                a_cnt = '0;
            end else begin
                if (a_out_valid && a_out_ready) begin
                    if (a_q.size() != 0) void'(a_q.pop_front());
                    a_occ--;
                    a_cnt++;
                end
                if (a_in_valid && a_in_ready) a_occ++;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("b_in_ready", 64'(b_in_ready), 64'(b_occ != 2));
            chk("b_out_valid", 64'(b_out_valid), 64'(b_occ != 0));
            chk("b_blk_count", 64'(b_blk_count), 64'(b_cnt));
            if (b_out_valid) begin
                chk("b_output_expected", 64'(b_q.size() != 0), 64'(1));
                if (b_q.size() != 0) chk("b_out_text", b_out_text, b_q[0]);
            end
            if (rst) begin
                b_occ = 0;
                b_cnt = '0;
            end else begin
                if (b_out_valid && b_out_ready) begin
                    if (b_q.size() != 0) void'(b_q.pop_front());
                    b_occ--;
                    b_cnt++;
                end
                if (b_in_valid && b_in_ready) b_occ++;
            end
        end
    end

    task automatic issue_a(input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp);
        a_left = l;
        a_right = r;
        a_in_valid = 1'b1;
        a_q.push_back(exp);
    endtask

    task automatic wait_acc_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_in_ready && n < 200);
        if (!a_in_ready) begin
            timeout_fail("a_accept");
            void'(a_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp);
        issue_a(l, r, exp);
        wait_acc_a();
    endtask

    task automatic send_b(input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp);
        int n = 0;
        b_left = l;
        b_right = r;
        b_in_valid = 1'b1;
        b_q.push_back(exp);
        do begin
            @(negedge clk);
            n++;
        end while (!b_in_ready && n < 200);
        if (!b_in_ready) begin
            timeout_fail("b_accept");
            void'(b_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((a_occ != 0 || b_occ != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (a_occ != 0 || b_occ != 0) timeout_fail("drain");
        chk("a_queue_empty", 64'(a_q.size()), 64'(0));
        chk("b_queue_empty", 64'(b_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        a_q.delete();
        b_q.delete();
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] x, ipx;
        logic [31:0] l, r;
        logic [15:0] cnt0;
        int          cyc0;

        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        a_left = '0; a_right = '0; b_left = '0; b_right = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("reset_a_in_ready", 64'(a_in_ready), 64'(1));
        chk("reset_a_blk_count", 64'(a_blk_count), 64'(0));
        chk("reset_b_blk_count", 64'(b_blk_count), 64'(0));
        @(posedge clk);
        #1;

        // Known vectors, first one checked for single-cycle latency.
        a_out_ready = 1'b1;
        send_a(32'h00000001, 32'h00000000, 64'h0200000000000000);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("latency1_valid", 64'(a_out_valid), 64'(1));
        chk("latency1_text", a_out_text, 64'h0200000000000000);
        @(posedge clk);
        #1;
        send_a(32'h00000000, 32'h80000000, 64'h0000000000000040);
        send_a(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        a_in_valid = 1'b0;
        drain();

        // Random data with random input gaps and random downstream stalls.
        rr_a = 1'b1;
        for (int k = 0; k < 200; k++) begin
            l = $urandom;
            r = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a_in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_a(l, r, fp_model({r, l}));
        end
        a_in_valid = 1'b0;
        rr_a = 1'b0;
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        drain();

        // Backpressure: two fill the FIFO, the third waits upstream.
        do_reset();
        a_out_ready = 1'b0;
        send_a(32'h11111111, 32'h22222222, fp_model({32'h22222222, 32'h11111111}));
        send_a(32'h33333333, 32'h44444444, fp_model({32'h44444444, 32'h33333333}));
        issue_a(32'h55555555, 32'h66666666, fp_model({32'h66666666, 32'h55555555}));
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready_low", 64'(a_in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        wait_acc_a();
        a_in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("backpressure_blk_count", 64'(a_blk_count), 64'(3));
        @(posedge clk);
        #1;

        // Steady streaming: one push per cycle with no stalls.
        cnt0 = a_cnt;
        cyc0 = cyc;
        for (int k = 0; k < 100; k++) begin
            l = $urandom;
            r = $urandom;
            send_a(l, r, fp_model({r, l}));
        end
        chk("stream_cycles", 64'(cyc - cyc0), 64'(100));
        chk("stream_outputs", 64'(16'(a_cnt - cnt0)), 64'(99));
        chk("stream_occupancy", 64'(a_occ), 64'(1));
        a_in_valid = 1'b0;
        drain();

        // Reset with a full FIFO; the coinciding pop and push are dropped.
        a_out_ready = 1'b0;
        send_a(32'hDEADBEEF, 32'h01234567, fp_model({32'h01234567, 32'hDEADBEEF}));
        send_a(32'hCAFEF00D, 32'h89ABCDEF, fp_model({32'h89ABCDEF, 32'hCAFEF00D}));
        a_out_ready = 1'b1;
        issue_a(32'h0F0F0F0F, 32'hF0F0F0F0, 64'h0);
        do_reset();
        a_out_ready = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(a_out_valid), 64'(0));
        chk("midreset_in_ready", 64'(a_in_ready), 64'(1));
        chk("midreset_blk_count", 64'(a_blk_count), 64'(0));
        @(posedge clk);
        #1;

        // IP then FP round trip on the unswapped instance; its 4-bit counter wraps.
        rr_b = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            x = {$urandom, $urandom};
            ipx = ip_model(x);
            send_b(ipx[63:32], ipx[31:0], x);
        end
        b_in_valid = 1'b0;
        rr_b = 1'b0;
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("b_wrapped_blk_count", 64'(b_blk_count), 64'(1000 % 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
